// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding, load-use stall FSM and saturating activity counters
//
// Ports:
//   clk_i              rising-edge clock
//   rst_n_i            synchronous active-low reset; while low, stall/flush/forward outputs are forced to 0
//   hold_i             global freeze: FSM state, stall counter and statistics counters keep their values
//   id_src_i           ID-stage source register numbers, operand i at [i*REG_AW +: REG_AW]
//   id_src_used_i      bit i set when ID operand i is actually read
//   idex_src_i         EX-stage source register numbers, same packing as id_src_i
//   idex_rd_i          EX-stage destination register
//   idex_memread_i     EX-stage instruction is a load
//   exmem_rd_i         EX/MEM destination register
//   exmem_regwrite_i   EX/MEM writes the register file
//   memwb_rd_i         MEM/WB destination register
//   memwb_regwrite_i   MEM/WB writes the register file
//   cnt_clear_i        synchronous clear of all statistics counters (works under hold too)
//   fwd_sel_o          2 bits per operand: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_o            hold PC and IF/ID
//   flush_idex_o       insert a bubble into ID/EX
//   cnt_exfwd_o        cycles with at least one EX/MEM forward
//   cnt_memfwd_o       cycles with at least one MEM/WB forward
//   cnt_stall_o        cycles with stall asserted
module hazard_forward_unit #(
    parameter int REG_AW     = 5,
    parameter int N_SRC      = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      hold_i,
    input  logic [N_SRC*REG_AW-1:0]   id_src_i,
    input  logic [N_SRC-1:0]          id_src_used_i,
    input  logic [N_SRC*REG_AW-1:0]   idex_src_i,
    input  logic [REG_AW-1:0]         idex_rd_i,
    input  logic                      idex_memread_i,
    input  logic [REG_AW-1:0]         exmem_rd_i,
    input  logic                      exmem_regwrite_i,
    input  logic [REG_AW-1:0]         memwb_rd_i,
    input  logic                      memwb_regwrite_i,
    input  logic                      cnt_clear_i,
    output logic [2*N_SRC-1:0]        fwd_sel_o,
    output logic                      stall_o,
    output logic                      flush_idex_o,
    output logic [CNT_W-1:0]          cnt_exfwd_o,
    output logic [CNT_W-1:0]          cnt_memfwd_o,
    output logic [CNT_W-1:0]          cnt_stall_o
);
    typedef enum logic {IDLE, STALL} state_t;

    state_t             state_q, state_d;
    logic [3:0]         scnt_q, scnt_d;
    logic [CNT_W-1:0]   cnt_exfwd_q, cnt_memfwd_q, cnt_stall_q;
    logic [2*N_SRC-1:0] fwd_sel;
    logic               ex_ok, mem_ok, any_ex, any_mem, lu_hit, lu, stall_raw;

    // Register 0 is hardwired, so a write to it never produces a forward
    assign ex_ok  = exmem_regwrite_i && (exmem_rd_i != '0);
    assign mem_ok = memwb_regwrite_i && (memwb_rd_i != '0);

    // EX/MEM holds the younger result, so it takes priority over MEM/WB
    always_comb begin
        fwd_sel = '0;
        any_ex  = 1'b0;
        any_mem = 1'b0;
        lu_hit  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            fwd_sel[2*i +: 2] = !rst_n_i ? 2'b00 :
                                (ex_ok && exmem_rd_i == idex_src_i[i*REG_AW +: REG_AW]) ? 2'b01 :
                                (mem_ok && memwb_rd_i == idex_src_i[i*REG_AW +: REG_AW]) ? 2'b10 : 2'b00;
            any_ex  = any_ex  | (fwd_sel[2*i +: 2] == 2'b01);
            any_mem = any_mem | (fwd_sel[2*i +: 2] == 2'b10);
            lu_hit  = lu_hit  | (id_src_used_i[i] && id_src_i[i*REG_AW +: REG_AW] == idex_rd_i);
        end
    end

    assign lu = idex_memread_i && (idex_rd_i != '0) && lu_hit;

    // IDLE issues the first bubble combinationally; STALL covers the remaining LOAD_STALL-1,
    // with scnt counting the bubbles still owed after the current one
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        stall_raw = lu;
        if (state_q == STALL) begin
            stall_raw = 1'b1;
            if (scnt_q == 4'd0)
                state_d = IDLE;
            else
                scnt_d = scnt_q - 4'd1;
        end else if (lu && LOAD_STALL > 1) begin
            state_d = STALL;
            scnt_d  = 4'(LOAD_STALL - 2);
        end
    end

    assign fwd_sel_o    = fwd_sel;
    assign stall_o      = rst_n_i && stall_raw;
    assign flush_idex_o = rst_n_i && stall_raw;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            scnt_q  <= 4'd0;
        end else if (!hold_i) begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    // Clear beats increment and is honoured regardless of hold
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || cnt_clear_i) begin
            cnt_exfwd_q  <= '0;
            cnt_memfwd_q <= '0;
            cnt_stall_q  <= '0;
        end else if (!hold_i) begin
            cnt_exfwd_q  <= sat_inc(cnt_exfwd_q, any_ex);
            cnt_memfwd_q <= sat_inc(cnt_memfwd_q, any_mem);
            cnt_stall_q  <= sat_inc(cnt_stall_q, stall_o);
        end
    end

    assign cnt_exfwd_o  = cnt_exfwd_q;
    assign cnt_memfwd_o = cnt_memfwd_q;
    assign cnt_stall_o  = cnt_stall_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: scoreboard bench for hazard_forward_unit (LOAD_STALL=3 unit A, LOAD_STALL=1/CNT_W=4 unit B)
module tb_hazard_forward_unit;
    logic        clk = 1'b0;
    logic        rst_n, hold, cnt_clear;
    logic [9:0]  id_src, idex_src;
    logic [1:0]  id_used;
    logic [4:0]  idex_rd, exmem_rd, memwb_rd;
    logic        idex_memread, exmem_rw, memwb_rw;

    logic [3:0]  fwd_a, fwd_b;
    logic        stall_a, flush_a, stall_b, flush_b;
    logic [15:0] ex_a, mem_a, st_a;
    logic [3:0]  ex_b, mem_b, st_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(5), .N_SRC(2), .LOAD_STALL(3), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .hold_i(hold), .id_src_i(id_src), .id_src_used_i(id_used),
        .idex_src_i(idex_src), .idex_rd_i(idex_rd), .idex_memread_i(idex_memread),
        .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_rw), .memwb_rd_i(memwb_rd),
        .memwb_regwrite_i(memwb_rw), .cnt_clear_i(cnt_clear), .fwd_sel_o(fwd_a),
        .stall_o(stall_a), .flush_idex_o(flush_a), .cnt_exfwd_o(ex_a), .cnt_memfwd_o(mem_a),
        .cnt_stall_o(st_a)
    );

    hazard_forward_unit #(.REG_AW(5), .N_SRC(2), .LOAD_STALL(1), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .hold_i(hold), .id_src_i(id_src), .id_src_used_i(id_used),
        .idex_src_i(idex_src), .idex_rd_i(idex_rd), .idex_memread_i(idex_memread),
        .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_rw), .memwb_rd_i(memwb_rd),
        .memwb_regwrite_i(memwb_rw), .cnt_clear_i(cnt_clear), .fwd_sel_o(fwd_b),
        .stall_o(stall_b), .flush_idex_o(flush_b), .cnt_exfwd_o(ex_b), .cnt_memfwd_o(mem_b),
        .cnt_stall_o(st_b)
    );

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0:       return 32'(fwd_a);
            1:       return 32'(stall_a);
            2:       return 32'(flush_a);
            3:       return 32'(ex_a);
            4:       return 32'(mem_a);
            5:       return 32'(st_a);
            6:       return 32'(ex_b);
            7:       return 32'(stall_b);
            8:       return 32'(flush_b);
            9:       return 32'(fwd_b);
            10:      return 32'(mem_b);
            default: return 32'(st_b);
        endcase
    endfunction

    // Monitor: outputs are presented every cycle; compare everything queued for this cycle
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = sample(e.sel);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input int sel, input int exp, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = 32'(exp);
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; hold = 0; cnt_clear = 0;
        id_src = {5'd8, 5'd0}; id_used = 2'b10; idex_src = {5'd0, 5'd5};
        idex_rd = 5'd8; idex_memread = 1; exmem_rd = 5'd5; exmem_rw = 1; memwb_rd = 0; memwb_rw = 0;
        step();
        chk(0, 0, "rst_fwd"); chk(1, 0, "rst_stall"); chk(2, 0, "rst_flush"); chk(7, 0, "rst_stall_b");
        chk(3, 0, "rst_cnt_ex"); chk(4, 0, "rst_cnt_mem"); chk(5, 0, "rst_cnt_stall");
        step();
        exmem_rw = 0; idex_memread = 0; id_used = 0; idex_src = 0; rst_n = 1;
        step();
        // forwarding priority and per-operand selection
        exmem_rd = 5; exmem_rw = 1; memwb_rd = 5; memwb_rw = 1; idex_src = {5'd7, 5'd5};
        chk(0, 4'b0001, "fwd_prio"); chk(9, 4'b0001, "fwd_prio_b"); chk(3, 0, "cnt_ex_t1");
        step();
        exmem_rw = 0;
        chk(0, 4'b0010, "fwd_memwb"); chk(3, 1, "cnt_ex_t2"); chk(4, 0, "cnt_mem_t2");
        step();
        exmem_rw = 1; exmem_rd = 7;
        chk(0, 4'b0110, "fwd_both"); chk(4, 1, "cnt_mem_t3");
        step();
        exmem_rd = 0; memwb_rd = 0; idex_src = 0;
        chk(0, 0, "fwd_zero"); chk(3, 2, "cnt_ex_t4");
        step();
        exmem_rw = 0; memwb_rw = 0;
        chk(3, 2, "zero_no_count"); chk(4, 2, "cnt_mem_t5"); chk(6, 2, "cnt_ex_b_t5");
        step();
        // load-use: bubble leaves EX after the first stall cycle
        idex_memread = 1; idex_rd = 8; id_src = {5'd8, 5'd3}; id_used = 2'b10;
        chk(1, 1, "lu_stall0"); chk(2, 1, "lu_flush0"); chk(7, 1, "lu_stall0_b"); chk(8, 1, "lu_flush0_b");
        step();
        idex_memread = 0;
        chk(1, 1, "lu_stall1"); chk(2, 1, "lu_flush1"); chk(7, 0, "lu_single_b");
        step();
        chk(1, 1, "lu_stall2");
        step();
        chk(1, 0, "lu_end"); chk(2, 0, "lu_end_flush"); chk(5, 3, "cnt_stall_3");
        step();
        idex_memread = 1; id_used = 2'b01;
        chk(1, 0, "lu_unused"); chk(7, 0, "lu_unused_b");
        step();
        idex_rd = 0; id_src = 0; id_used = 2'b11;
        chk(1, 0, "lu_r0");
        step();
        // hold during stall
        idex_rd = 8; id_src = {5'd8, 5'd3}; id_used = 2'b10;
        chk(1, 1, "h0_stall"); chk(5, 3, "h0_cnt");
        step();
        idex_memread = 0; hold = 1;
        chk(1, 1, "h1_stall"); chk(5, 4, "h1_cnt");
        step();
        exmem_rw = 1; exmem_rd = 9; idex_src = {5'd0, 5'd9};
        chk(1, 1, "h2_stall"); chk(0, 4'b0001, "fwd_in_hold"); chk(5, 4, "h2_cnt");
        step();
        exmem_rw = 0;
        chk(1, 1, "h3_stall"); chk(3, 2, "ex_frozen"); chk(5, 4, "h3_cnt");
        step();
        chk(1, 1, "h4_stall"); chk(5, 4, "h4_cnt");
        step();
        hold = 0;
        chk(1, 1, "h5_stall"); chk(5, 4, "h5_cnt");
        step();
        chk(1, 1, "h6_stall"); chk(5, 5, "h6_cnt");
        step();
        chk(1, 0, "h7_stall"); chk(5, 6, "h7_cnt");
        step();
        // reset in the middle of a stall
        idex_memread = 1;
        chk(1, 1, "r0_stall");
        step();
        idex_memread = 0; rst_n = 0;
        chk(1, 0, "stall_in_rst"); chk(2, 0, "flush_in_rst");
        step();
        rst_n = 1;
        chk(1, 0, "stall_after_rst"); chk(5, 0, "rst_st"); chk(3, 0, "rst_ex"); chk(4, 0, "rst_mem");
        chk(6, 0, "rst_ex_b");
        step();
        // counter clear beats an active forward, also under hold
        exmem_rw = 1;
        chk(0, 4'b0001, "c1_fwd"); chk(3, 0, "c1_ex");
        step();
        chk(3, 1, "c2_ex");
        step();
        cnt_clear = 1;
        chk(3, 2, "c3_ex");
        step();
        cnt_clear = 0;
        chk(3, 0, "clear_wins"); chk(6, 0, "clear_wins_b");
        step();
        hold = 1; cnt_clear = 1;
        chk(3, 1, "c5_ex");
        step();
        hold = 0; cnt_clear = 0; exmem_rw = 0;
        chk(3, 0, "clear_in_hold"); chk(6, 0, "clear_in_hold_b");
        step();
        // saturation of the 4-bit counter
        exmem_rw = 1;
        for (int k = 0; k < 20; k++) begin
            chk(6, (k > 15) ? 15 : k, "sat_ramp");
            step();
        end
        chk(6, 15, "sat_hold"); chk(3, 20, "ex_a_20"); chk(11, 0, "st_b_zero"); chk(10, 0, "mem_b_zero");
        exmem_rw = 0;
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipeline. It generates per-operand forwarding selects for N_SRC source operands in EX. It also detects load-use hazards in ID and runs a stall FSM that holds PC/IF-ID and flushes ID/EX for a configurable number of cycles. Saturating event counters record forwarding and stall activity for performance analysis.

Parameters:
REG_AW, 5, register address width
N_SRC, 2, number of source operands per instruction
LOAD_STALL, 1, bubble cycles per load-use hazard (1..15)
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
hold  in  1  global pipeline freeze (cache miss); freezes FSM and counters
id_src  in  N_SRC*REG_AW  source register numbers of instruction in ID, operand i at [i*REG_AW +: REG_AW]
id_src_used  in  N_SRC  bit i=1: operand i is read by the ID instruction
idex_src  in  N_SRC*REG_AW  source register numbers of instruction in EX
idex_rd  in  REG_AW  destination of instruction in EX
idex_memread  in  1  instruction in EX is a load
exmem_rd  in  REG_AW  destination in EX/MEM
exmem_regwrite  in  1  EX/MEM writes register file
memwb_rd  in  REG_AW  destination in MEM/WB (load rt already muxed to rd upstream)
memwb_regwrite  in  1  MEM/WB writes register file
cnt_clear  in  1  synchronous clear of all counters
fwd_sel  out  2*N_SRC  per-operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 unused
stall  out  1  hold PC and IF/ID
flush_idex  out  1  insert bubble into ID/EX
cnt_exfwd  out  CNT_W  cycles with at least one EX/MEM forward
cnt_memfwd  out  CNT_W  cycles with at least one MEM/WB forward
cnt_stall  out  CNT_W  cycles with stall asserted

Behaviour:
- Forwarding is combinational and evaluated per operand i.
- fwd_sel[i] = 01 if exmem_regwrite, exmem_rd!=0, and exmem_rd==idex_src[i].
- Else fwd_sel[i] = 10 if memwb_regwrite, memwb_rd!=0, and memwb_rd==idex_src[i].
- Else fwd_sel[i] = 00. EX/MEM has priority over MEM/WB. Encoding 11 is never driven.
- Register 0 never matches in either stage.
- Load-use detect is combinational: lu = idex_memread & idex_rd!=0 & OR over i of (id_src_used[i] & id_src[i]==idex_rd).
- FSM states are IDLE and STALL, with a 4-bit down-counter scnt.
- IDLE: stall = flush_idex = lu.
- IDLE, lu=1 and LOAD_STALL>1: go to STALL and load scnt=LOAD_STALL-2.
- IDLE, lu=1 and LOAD_STALL==1: stay in IDLE. This gives exactly one bubble.
- STALL: stall=1 and flush_idex=1 unconditionally; lu is ignored.
- STALL: if scnt==0, go to IDLE; otherwise decrement scnt.
- Total stall cycles per hazard = LOAD_STALL.
- hold=1: state, scnt and counters keep their values. Combinational outputs still track inputs.
- Counters: each increments by 1 per non-hold cycle in which its condition is true. They saturate at all-ones with no wrap.
- cnt_clear=1 zeroes all counters and wins over a same-cycle increment. cnt_clear is honoured even when hold=1.
- Reset (rst_n=0 at a clock edge): state=IDLE, scnt=0, all counters=0.
- Reset mid-STALL aborts the stall. stall drops in the cycle after the reset edge unless lu is true then.
- While rst_n=0, stall and flush_idex are forced to 0, and fwd_sel is forced to all 00.
- Latency: fwd_sel and the first stall cycle have 0 latency (same cycle). STALL-state cycles follow on consecutive non-hold edges.

Test Plan:
- Forwarding priority:
  - Stimulus: exmem_rd=5 regwrite=1, memwb_rd=5 regwrite=1, idex_src0=5, idex_src1=7.
  - Required: fwd_sel=00_01 (op1=00, op0=01).
  - Then drop exmem_regwrite: fwd_sel op0=10.
- Zero register:
  - Stimulus: exmem_rd=0 regwrite=1, idex_src0=0.
  - Required: fwd_sel op0=00, and cnt_exfwd unchanged after a clock edge.
- Load-use with LOAD_STALL=3:
  - Stimulus: idex_memread=1 idex_rd=8, id_src1=8 used.
  - Required: stall=flush_idex=1 for exactly 3 consecutive cycles, then 0; cnt_stall=3.
  - Repeat with id_src_used1=0: no stall.
- Hold during stall (LOAD_STALL=3):
  - Stimulus: assert hold for 4 cycles after the first stall cycle.
  - Required: stall stays 1 and cnt_stall is frozen during hold; after hold releases, exactly 2 further stall cycles follow.
- Reset mid-stall and counter clear:
  - Stimulus: pulse rst_n=0 during STALL.
  - Required: next cycle stall=0 (lu=0) and all counters 0.
  - Stimulus: assert cnt_clear together with an active forward.
  - Required: counter=0.
- Saturation with CNT_W=4:
  - Stimulus: 20 cycles of EX/MEM forwarding.
  - Required: cnt_exfwd=15, no wrap.
